regfile_dumper: RTL and testbench

REGFILE_DUMPER -- requirements
Module: regfile_dumper

---
 rtl/regfile_dumper.sv | 119 +++++++++++
 tb/tb_regfile_dumper.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dumper.sv
// Streams every register of an external register file out over a valid/ready port.
// Define REGFILE_DUMP_SKIP_X0_EN to start at index 1 and never emit register 0.
module regfile_dumper #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ADDRESS_WIDTH-1:0] out_addr,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDRESS_WIDTH-1:0] LastIdx = '1;
`ifdef REGFILE_DUMP_SKIP_X0_EN
  localparam logic [ADDRESS_WIDTH-1:0] FirstIdx = ADDRESS_WIDTH'(1);
`else
  localparam logic [ADDRESS_WIDTH-1:0] FirstIdx = '0;
`endif

  typedef enum logic [1:0] {StIdle, StRead, StSend, StFin} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     xfer;

  // Only a presented word can be accepted; out_ready alone means nothing.
  assign xfer = valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = FirstIdx;
          state_d = StRead;
        end
      end
      StRead: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          data_d  = rd_data;
          addr_d  = cnt_q;
          valid_d = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        // An accepted word coinciding with abort still counts; abort only picks the exit.
        if (abort) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (xfer) begin
          valid_d = 1'b0;
          if (cnt_q == LastIdx) begin
            state_d = StFin;
          end else begin
            cnt_d   = cnt_q + ADDRESS_WIDTH'(1);
            state_d = StRead;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StFin) & ~abort;
    rd_addr = (state_q == StRead) ? cnt_q : '0;
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: cycle table for the handshake, then dump, stall, abort,
// reset and restart sequences against a register model where reg[i] = 0x100 + i.
module tb_regfile_dumper;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NReg = 32;
`ifdef REGFILE_DUMP_SKIP_X0_EN
  localparam int First = 1;
`else
  localparam int First = 0;
`endif
  localparam int NWords  = NReg - First;
  localparam int DoneLat = 2 * NWords;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rd_addr, out_addr;
  logic [DW-1:0] rd_data, out_data;
  logic          out_valid, busy, done;

  regfile_dumper #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done)
  );

  assign rd_data = 32'h100 + {27'b0, rd_addr};

  always #5 clk = ~clk;

  int          passed = 0;
  int          total = 0;
  int unsigned edge_cnt = 0;
  int          done_cnt = 0;
  int unsigned done_edge = 0;
  logic [AW-1:0] xfer_addr[$];
  logic [DW-1:0] xfer_data[$];

  always @(posedge clk) edge_cnt++;

  // Inputs only change just after posedge, so what is seen here is what the next edge takes.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      xfer_addr.push_back(out_addr);
      xfer_data.push_back(out_data);
    end
    if (done) begin
      done_cnt++;
      done_edge = edge_cnt;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    xfer_addr.delete();
    xfer_data.delete();
    done_cnt = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    if (busy) check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_word(input int a, input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      if (out_valid && int'(out_addr) == a) ok = 1'b1;
      else begin
        step();
        n++;
      end
    end
  endtask

  function automatic int count_addr(input int a);
    int c = 0;
    foreach (xfer_addr[k]) if (int'(xfer_addr[k]) == a) c++;
    return c;
  endfunction

  typedef struct {
    logic        start;
    logic        ready;
    logic        abort;
    logic        exp_valid;
    logic        exp_busy;
    logic        exp_done;
    logic [31:0] exp_rd_addr;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit          ok;
    int unsigned start_edge;
    int          bad;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'(First),     32'd0, 32'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'(First), 32'(32'h100 + First)};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'(First), 32'(32'h100 + First)};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'(First + 1), 32'd0, 32'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'(First + 1),
                32'(32'h101 + First)};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};

    // Reset state
    step(2);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst_n = 1'b1;

    // Cycle table: start right after reset release, one stall, one transfer, abort in SEND
    for (int i = 0; i < 7; i++) begin
      start     = vecs[i].start;
      out_ready = vecs[i].ready;
      abort     = vecs[i].abort;
      step();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_rd_addr", i), 32'(rd_addr), vecs[i].exp_rd_addr);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_out_addr", i), 32'(out_addr), vecs[i].exp_addr);
        check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
      end
    end
    abort = 1'b0;

    // Full dump with out_ready held high
    clear_mon();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    start_edge = edge_cnt;
    wait_idle("dump_timeout", 200);
    step();
    check("dump_words", 32'(xfer_addr.size()), 32'(NWords));
    bad = 0;
    foreach (xfer_addr[k])
      if (int'(xfer_addr[k]) != First + k || xfer_data[k] != 32'(32'h100 + First + k)) bad++;
    check("dump_order_errors", 32'(bad), 32'd0);
    check("dump_done_pulses", 32'(done_cnt), 32'd1);
    check("dump_done_latency", 32'(done_edge - start_edge), 32'(DoneLat));

    // Stall at word 7
    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_word(7, 40, ok);
    check("stall_reach_w7", 32'(ok), 32'd1);
    out_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!(out_valid && out_addr == 5'd7 && out_data == 32'h107)) bad++;
    end
    check("stall_hold_errors", 32'(bad), 32'd0);
    out_ready = 1'b1;
    wait_idle("stall_timeout", 200);
    step();
    check("stall_w7_once", 32'(count_addr(7)), 32'd1);
    check("stall_words", 32'(xfer_addr.size()), 32'(NWords));
    check("stall_done_pulses", 32'(done_cnt), 32'd1);

    // Abort at word 10 in SEND, coinciding with a transfer
    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_word(10, 40, ok);
    check("abort_reach_w10", 32'(ok), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    step(4);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_words", 32'(xfer_addr.size()), 32'(11 - First));
    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_word(First, 4, ok);
    check("restart_first_word", 32'(ok), 32'd1);
    check("restart_first_addr", 32'(out_addr), 32'(First));
    wait_idle("restart_timeout", 200);

    // Asynchronous reset mid-SEND
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_word(First, 4, ok);
    check("rstmid_in_send", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_out_data", out_data, 32'd0);
    check("rstmid_out_addr", 32'(out_addr), 32'd0);
    step(2);
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("rst_release_start", 32'(busy), 32'd1);
    check("rst_release_rd_addr", 32'(rd_addr), 32'(First));
    out_ready = 1'b1;
    wait_idle("rst_release_timeout", 200);

    // Start re-pulsed while busy
    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    step(5);
    start = 1'b1;
    step();
    start = 1'b0;
    step(20);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("repulse_timeout", 200);
    step(3);
    check("repulse_words", 32'(xfer_addr.size()), 32'(NWords));
    check("repulse_done_pulses", 32'(done_cnt), 32'd1);
    check("repulse_idle_after", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
